// File: rtl/hpdcache_pkg.sv
// Shared types for the round-robin grant scheduler.
// FSM state encoding and handshake counter width.
package hpdcache_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } sched_state_e;

  localparam int unsigned HS_CNT_W = 32;

endpackage

// File: rtl/hpdcache_1hot_to_binary.sv
// One-hot to binary index encoder; zero input gives index 0.
// Ports: onehot (N) in, bin (Log2N) out.
module hpdcache_1hot_to_binary #(
  parameter  int unsigned N     = 4,
  localparam int unsigned Log2N = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]     onehot,
  output logic [Log2N-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) bin = bin | Log2N'(i);
    end
  end

endmodule

// File: rtl/hpdcache_rr_grant_scheduler.sv
// Round-robin scheduler sharing one ready/valid port among N requesters.
// Ports: clk_i, rst_ni, req_valid_i/req_ready_o (N), gnt_valid_o,
// gnt_ready_i, gnt_o (N), gnt_idx_o (Log2N), hs_cnt_o (32).
// Macros: HPDCACHE_RR_SCHED_HS_CNT_EN enables the handshake counter,
// HPDCACHE_ASSERT_OFF removes the locked-grant protocol assertion.
module hpdcache_rr_grant_scheduler
  import hpdcache_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned Log2N = N > 1 ? $clog2(N) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N-1:0]        req_valid_i,
  output logic [N-1:0]        req_ready_o,
  output logic                gnt_valid_o,
  input  logic                gnt_ready_i,
  output logic [N-1:0]        gnt_o,
  output logic [Log2N-1:0]    gnt_idx_o,
  output logic [HS_CNT_W-1:0] hs_cnt_o
);

  sched_state_e state_q, state_d;
  logic [N-1:0] prio_q, prio_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [N-1:0] req_hi, winner, gnt;
  logic         gnt_valid, hs;

  function automatic logic [N-1:0] rotl1(input logic [N-1:0] x);
    return (x << 1) | (x >> (N - 1));
  endfunction

  // Requests at or above the priority position win first;
  // otherwise wrap to the lowest requester. x & -x isolates
  // the lowest set bit.
  always_comb begin
    req_hi = req_valid_i & ~(prio_q - N'(1));
    if (|req_hi) winner = req_hi & (~req_hi + N'(1));
    else winner = req_valid_i & (~req_valid_i + N'(1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= UNLOCKED;
      prio_q  <= N'(1);
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    if (hs) begin
      prio_d  = rotl1(gnt);
      state_d = UNLOCKED;
    end else if (gnt_valid && state_q == UNLOCKED) begin
      gnt_d   = winner;
      state_d = LOCKED;
    end
  end

  always_comb begin
    gnt       = winner;
    gnt_valid = |req_valid_i;
    unique case (state_q)
      UNLOCKED: ;
      LOCKED: begin
        gnt       = gnt_q;
        gnt_valid = 1'b1;
      end
    endcase
  end

  assign hs          = gnt_valid & gnt_ready_i;
  assign gnt_o       = gnt;
  assign gnt_valid_o = gnt_valid;
  assign req_ready_o = gnt & {N{gnt_ready_i}};

  hpdcache_1hot_to_binary #(
    .N(N)
  ) i_enc (
    .onehot(gnt),
    .bin   (gnt_idx_o)
  );

`ifdef HPDCACHE_RR_SCHED_HS_CNT_EN
  logic [HS_CNT_W-1:0] hs_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hs_cnt_q <= '0;
    else if (hs && !(&hs_cnt_q)) hs_cnt_q <= hs_cnt_q + HS_CNT_W'(1);
  end

  assign hs_cnt_o = hs_cnt_q;
`else
  assign hs_cnt_o = '0;
`endif

`ifndef HPDCACHE_ASSERT_OFF
  lock_hold_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (state_q == LOCKED) |-> |(req_valid_i & gnt_q)
  ) else $error("granted request dropped while locked");
`endif

endmodule

// File: doc/hpdcache_rr_grant_scheduler.md
# hpdcache_rr_grant_scheduler

Round-robin scheduler that shares one downstream ready/valid resource port (e.g. a refill/write-buffer slot or memory request channel) between N requesters. It picks one requester per transaction, holds the grant stable until the downstream handshake completes, and exports the grant both one-hot and as a binary index. The binary index drives the select of the cache's request-field muxes.

## Interface
- Parameters:
  - N, default 4: number of requesters; legal range 1..32.
  - Log2N, localparam, N > 1 ? $clog2(N) : 1: index width.
- Ports:
  - clk_i  input  1  clock; all state updates on the rising edge.
  - rst_ni  input  1  reset, asynchronous and active-low.
  - req_valid_i  input  N  per-requester request valid.
  - req_ready_o  output  N  per-requester ready; one-hot or zero.
  - gnt_valid_o  output  1  downstream valid.
  - gnt_ready_i  input  1  downstream ready.
  - gnt_o  output  N  granted requester, one-hot or zero.
  - gnt_idx_o  output  Log2N  binary index of gnt_o; 0 when gnt_o is 0.
  - hs_cnt_o  output  32  count of completed downstream handshakes (see Configuration).

## Operation
- State registers:
  - prio_q, N-bit one-hot: highest-priority requester. Reset value is bit 0.
  - locked_q, 1 bit: reset value 0.
  - gnt_q, N-bit: reset value 0.
  - FSM state follows locked_q: UNLOCKED (0) or LOCKED (1).
- UNLOCKED:
  - The winner is the first set bit of req_valid_i, searching upward from the position of prio_q and wrapping from N-1 to 0.
  - gnt_o = winner (combinational). gnt_valid_o = |req_valid_i.
  - If gnt_valid_o && gnt_ready_i, the handshake completes. prio_q takes the winner rotated left by 1 (bit N-1 wraps to bit 0). The FSM stays UNLOCKED.
  - If gnt_valid_o && !gnt_ready_i, gnt_q takes the winner and the FSM goes to LOCKED.
- LOCKED:
  - gnt_o = gnt_q and gnt_valid_o = 1. req_valid_i is ignored for arbitration.
  - On gnt_ready_i, the handshake completes, prio_q takes gnt_q rotated left by 1, and the FSM returns to UNLOCKED.
  - A new arbitration starts the following cycle.
- Common to both states:
  - req_ready_o = gnt_o & {N{gnt_ready_i}}.
  - gnt_idx_o is the binary encoding of gnt_o.
- Protocol rules:
  - A requester must hold req_valid_i high until its req_ready_o is seen.
  - Deasserting a granted valid while LOCKED is a protocol error. The scheduler still completes the locked grant.
  - Unless HPDCACHE_ASSERT_OFF is defined, an assertion fires on this error.
- No requests: gnt_o = 0, gnt_idx_o = 0, gnt_valid_o = 0, and no state changes.
- N = 1: the single requester is always the winner. prio_q stays at 1. gnt_idx_o is constant 0.
- Reset asserted mid-transaction: all state returns to reset values immediately. Any locked grant is dropped without a handshake.

## Timing
- In UNLOCKED, request to grant is zero-latency combinational; a handshake is possible in the same cycle the request arrives.
- Throughput: one handshake per cycle when gnt_ready_i stays high.
- Fairness: a continuously requesting requester is granted within N handshakes.
- gnt_o, gnt_idx_o and gnt_valid_o never change while gnt_valid_o && !gnt_ready_i.
- The combinational path is req_valid_i → gnt_o → req_ready_o. There is no combinational path from gnt_ready_i to gnt_o.
- Reset values (no requests, in reset): gnt_valid_o = 0, gnt_o = 0, gnt_idx_o = 0, req_ready_o = 0, hs_cnt_o = 0.

## Configuration
- HPDCACHE_RR_SCHED_HS_CNT_EN defined:
  - hs_cnt_o is a 32-bit register, reset to 0.
  - It increments by 1 on every cycle with gnt_valid_o && gnt_ready_i.
  - It saturates at 32'hFFFF_FFFF.
- HPDCACHE_RR_SCHED_HS_CNT_EN undefined: no counter flops exist and hs_cnt_o is tied to 0.

## Structure
- Shared package hpdcache_pkg:
  - The FSM state enum (UNLOCKED, LOCKED).
  - The 32-bit counter width constant.
- Sub-module hpdcache_1hot_to_binary #(.N(N)) encodes gnt_o into gnt_idx_o.
- The rotate-priority search is local combinational logic.

## Test plan
- N=4, after reset, req_valid_i=4'b1111, gnt_ready_i=1 for 5 cycles → gnt_idx_o sequence 0,1,2,3,0; hs_cnt_o=5 (with macro).
- Wrap-around: prio at bit 3, req_valid_i=4'b0101 → gnt_o=4'b0001, then gnt_o=4'b0100 next cycle.
- Backpressure:
  - Stimulus: req_valid_i=4'b0110, gnt_ready_i=0 for 3 cycles; in cycle 2 req_valid_i changes to 4'b0111; gnt_ready_i=1 in cycle 4.
  - Response: gnt_o stays 4'b0010 through cycle 4; req_ready_o=4'b0010 only in cycle 4; next grant is 4'b0100.
- No requests: req_valid_i=0, gnt_ready_i=1 for 10 cycles → gnt_valid_o=0, prio_q unchanged, hs_cnt_o unchanged.
- Reset mid-lock: LOCKED on requester 2, then rst_ni pulsed low → gnt_valid_o=0 while reset is asserted; after release with all requesting, first grant is index 0.
- Counter:
  - Macro defined, hs_cnt_o forced near 32'hFFFF_FFFE, 3 handshakes → hs_cnt_o=32'hFFFF_FFFF.
  - Macro undefined → hs_cnt_o=0 throughout.
